// File: rtl/digit_scroll_pkg.sv
// Shared types for the digit scroll feeder.
//   state_t    : feeder FSM states (message load, window scroll)
//   digit_t    : one 4-bit digit code
//   BLANK_CODE_DEFAULT : code used for padding and cleared windows
package digit_scroll_pkg;

    typedef enum logic [0:0] {
        StLoad   = 1'b0,
        StScroll = 1'b1
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BLANK_CODE_DEFAULT = 4'hA;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll prescaler: free-running counter 0..TICK_DIV-1 producing a one-cycle tick
// in the terminal-count cycle.
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   clr  : synchronous counter clear; also suppresses the tick in the same cycle
//   tick : one-cycle pulse at terminal count
module scroll_tick_gen #(
    parameter int unsigned TICK_DIV = 33554432
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/digit_scroll_feeder.sv
// Digit scroll feeder: loads a message of 4-bit digit codes over a valid/ready port,
// then presents a sliding 4-digit window that advances once per scroll tick.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous discard of the message, back to load
//   wr_en/wr_data/wr_last/wr_ready : message write port
//   digits        : window, [3:0] = leftmost digit
//   window_valid  : high while scrolling
//   step          : one-cycle pulse in the cycle digits changes
// Build option: define SCROLL_CIRCULAR_EN to treat the message as a ring
// (indices mod len, no blank padding, scrolls whenever len > 1).
module digit_scroll_feeder
    import digit_scroll_pkg::*;
#(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned TICK_DIV   = 33554432,
    parameter digit_t      BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [3:0]  wr_data,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic [15:0] digits,
    output logic        window_valid,
    output logic        step
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    // One spare bit so start+3 never overflows before the range compare.
    localparam int unsigned IW = LW + 1;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q;
    logic [AW-1:0] start_q, start_d;
    logic [15:0]   digits_q;
    logic          step_q;
    logic          refresh_q;   // start moved last cycle; reload digits now
    digit_t        mem_q [DEPTH];

    logic          wr_fire;
    logic          load_done;
    logic          tick;
    logic          tick_clr;
    logic          adv;
    logic [15:0]   window_next;

    assign wr_fire   = (state_q == StLoad) && wr_en && !clear;
    assign load_done = wr_fire && (wr_last || len_q == LW'(DEPTH - 1));
    assign tick_clr  = clear || (state_q != StScroll);

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        wr_ready     = 1'b0;
        window_valid = 1'b0;
        case (state_q)
            StLoad: begin
                wr_ready = 1'b1;
                if (load_done) state_d = StScroll;
            end
            StScroll: window_valid = 1'b1;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        start_d = start_q;
        adv     = 1'b0;
`ifdef SCROLL_CIRCULAR_EN
        if (tick && len_q > LW'(1)) begin
            adv     = 1'b1;
            start_d = (LW'(start_q) == len_q - LW'(1)) ? '0 : start_q + AW'(1);
        end
`else
        if (tick && len_q > LW'(4)) begin
            adv     = 1'b1;
            start_d = (LW'(start_q) == len_q - LW'(4)) ? '0 : start_q + AW'(1);
        end
`endif
    end

    // Window read muxes. On the final write the incoming digit is not yet in the
    // buffer, so it is bypassed in and the window starts at 0 with the new length.
    always_comb begin
        logic [LW-1:0] eff_len;
        logic [IW-1:0] base;
        logic [IW-1:0] idx;
        eff_len     = load_done ? len_q + LW'(1) : len_q;
        base        = load_done ? '0 : IW'(start_q);
        window_next = '0;
        idx         = '0;
        for (int k = 0; k < 4; k++) begin
            idx = base + IW'(k);
`ifdef SCROLL_CIRCULAR_EN
            // start+k < len+3, so three conditional subtracts give the modulo.
            for (int r = 0; r < 3; r++) begin
                if (idx >= IW'(eff_len)) idx = idx - IW'(eff_len);
            end
`endif
            if (idx >= IW'(eff_len)) begin
                window_next[4*k +: 4] = BLANK_CODE;
            end else if (load_done && idx == IW'(len_q)) begin
                window_next[4*k +: 4] = wr_data;
            end else begin
                window_next[4*k +: 4] = mem_q[idx[AW-1:0]];
            end
        end
    end

    // Buffer contents survive clear and reset; len gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[len_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            len_q     <= '0;
            start_q   <= '0;
            digits_q  <= {4{BLANK_CODE}};
            step_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else if (clear) begin
            state_q   <= StLoad;
            len_q     <= '0;
            start_q   <= '0;
            digits_q  <= {4{BLANK_CODE}};
            step_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= 1'b0;
            refresh_q <= adv;
            start_q   <= start_d;
            if (wr_fire) len_q <= len_q + LW'(1);
            if (load_done) begin
                start_q  <= '0;
                digits_q <= window_next;
                step_q   <= 1'b1;
            end else if (refresh_q) begin
                digits_q <= window_next;
                step_q   <= 1'b1;
            end
        end
    end

    assign digits = digits_q;
    assign step   = step_q;

endmodule

// File: tb/tb_digit_scroll_feeder.sv
module tb_digit_scroll_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_data = 4'h0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic [15:0] digits;
    logic        window_valid;
    logic        step;

    int checks = 0;
    int passed = 0;

    digit_scroll_feeder #(
        .DEPTH      (32),
        .TICK_DIV   (8),
        .BLANK_CODE (4'hA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .digits       (digits),
        .window_valid (window_valid),
        .step         (step)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack4(input logic [3:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Called at a negedge; returns at the next negedge with the write captured.
    task automatic write_digit(input logic [3:0] d, input logic last);
        wr_en   = 1'b1;
        wr_data = d;
        wr_last = last;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    // Advance negedges until step is seen (bounded); n = negedges waited.
    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < 40);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (digits !== 16'hAAAA) $display("FAIL reset_digits got %h want AAAA", digits); else passed++;
        checks++; if (window_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", window_valid); else passed++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", wr_ready); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL reset_step got %b want 0", step); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_scroll_long();
        logic [3:0]  msg [8];
        logic [15:0] exp_win [5];
        int n;
        msg = '{4'd1, 4'd5, 4'd0, 4'd1, 4'd1, 4'd6, 4'd0, 4'd6};
        exp_win = '{pack4(5,0,1,1), pack4(0,1,1,6), pack4(1,1,6,0), pack4(1,6,0,6), pack4(1,5,0,1)};
        for (int i = 0; i < 8; i++) write_digit(msg[i], i == 7);
        checks++; if (digits !== pack4(1,5,0,1)) $display("FAIL long_first got %h want %h", digits, pack4(1,5,0,1)); else passed++;
        checks++; if (step !== 1'b1) $display("FAIL long_first_step got %b want 1", step); else passed++;
        checks++; if (window_valid !== 1'b1) $display("FAIL long_valid got %b want 1", window_valid); else passed++;
        checks++; if (wr_ready !== 1'b0) $display("FAIL long_ready got %b want 0", wr_ready); else passed++;
        @(negedge clk);
        checks++; if (step !== 1'b0) $display("FAIL long_step_pulse got %b want 0", step); else passed++;
        for (int t = 0; t < 5; t++) begin
            wait_step(n);
            checks++;
            if (n !== ((t == 0) ? 8 : 8)) $display("FAIL long_tick%0d_latency got %0d want 8", t, n); else passed++;
            checks++;
            if (digits !== exp_win[t]) $display("FAIL long_tick%0d got %h want %h", t, digits, exp_win[t]); else passed++;
        end
    endtask

    task automatic test_short_static();
        int steps = 0;
        write_digit(4'd8, 1'b0);
        write_digit(4'd1, 1'b1);
        checks++; if (digits !== pack4(8,1,4'hA,4'hA)) $display("FAIL short_win got %h want %h", digits, pack4(8,1,4'hA,4'hA)); else passed++;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (step) steps++;
        end
        checks++; if (steps !== 0) $display("FAIL short_steps got %0d want 0", steps); else passed++;
        checks++; if (digits !== pack4(8,1,4'hA,4'hA)) $display("FAIL short_static got %h want %h", digits, pack4(8,1,4'hA,4'hA)); else passed++;
    endtask

    task automatic test_full_buffer();
        int n;
        for (int i = 0; i < 31; i++) write_digit(4'(i), 1'b0);
        checks++; if (wr_ready !== 1'b1) $display("FAIL full_ready31 got %b want 1", wr_ready); else passed++;
        write_digit(4'hF, 1'b0);
        checks++; if (wr_ready !== 1'b0) $display("FAIL full_ready32 got %b want 0", wr_ready); else passed++;
        checks++; if (window_valid !== 1'b1) $display("FAIL full_valid got %b want 1", window_valid); else passed++;
        checks++; if (digits !== pack4(0,1,2,3)) $display("FAIL full_first got %h want %h", digits, pack4(0,1,2,3)); else passed++;
        write_digit(4'h9, 1'b0);    // dropped
        for (int t = 0; t < 28; t++) begin
            wait_step(n);
            checks++; if (n !== 8) $display("FAIL full_tick%0d_latency got %0d want 8", t, n); else passed++;
        end
        checks++; if (digits !== pack4(12,13,14,15)) $display("FAIL full_last_win got %h want %h", digits, pack4(12,13,14,15)); else passed++;
        wait_step(n);
        checks++; if (digits !== pack4(0,1,2,3)) $display("FAIL full_wrap got %h want %h", digits, pack4(0,1,2,3)); else passed++;
    endtask

    task automatic test_clear();
        int n;
        int steps = 0;
        for (int i = 0; i < 5; i++) write_digit(4'(3 + i), i == 4);
        // Counter is 0 here; terminal count is visible 7 negedges later.
        for (int c = 0; c < 7; c++) @(negedge clk);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 4'h9;
        @(negedge clk);
        clear = 1'b0;
        wr_en = 1'b0;
        checks++; if (digits !== 16'hAAAA) $display("FAIL clear_digits got %h want AAAA", digits); else passed++;
        checks++; if (window_valid !== 1'b0) $display("FAIL clear_valid got %b want 0", window_valid); else passed++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL clear_ready got %b want 1", wr_ready); else passed++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (step) steps++;
        end
        checks++; if (steps !== 0) $display("FAIL clear_steps got %0d want 0", steps); else passed++;
        write_digit(4'd0, 1'b0);
        write_digit(4'd7, 1'b0);
        write_digit(4'd1, 1'b0);
        write_digit(4'd5, 1'b0);
        write_digit(4'd0, 1'b1);
        checks++; if (digits !== pack4(0,7,1,5)) $display("FAIL reload_first got %h want %h", digits, pack4(0,7,1,5)); else passed++;
        wait_step(n);
        checks++; if (n !== 9) $display("FAIL reload_latency got %0d want 9", n); else passed++;
        checks++; if (digits !== pack4(7,1,5,0)) $display("FAIL reload_tick1 got %h want %h", digits, pack4(7,1,5,0)); else passed++;
        wait_step(n);
`ifdef SCROLL_CIRCULAR_EN
        checks++; if (digits !== pack4(1,5,0,0)) $display("FAIL reload_tick2 got %h want %h", digits, pack4(1,5,0,0)); else passed++;
`else
        checks++; if (digits !== pack4(0,7,1,5)) $display("FAIL reload_tick2 got %h want %h", digits, pack4(0,7,1,5)); else passed++;
`endif
    endtask

    task automatic test_async_reset();
        int n;
        for (int i = 0; i < 5; i++) write_digit(4'(2 + i), i == 4);
        wait_step(n);
        checks++; if (digits !== pack4(3,4,5,6)) $display("FAIL arst_pre got %h want %h", digits, pack4(3,4,5,6)); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (digits !== 16'hAAAA) $display("FAIL arst_digits got %h want AAAA", digits); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL arst_step got %b want 0", step); else passed++;
        checks++; if (window_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", window_valid); else passed++;
        checks++; if (wr_ready !== 1'b1) $display("FAIL arst_ready got %b want 1", wr_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        write_digit(4'd7, 1'b1);
        checks++; if (digits !== pack4(7,4'hA,4'hA,4'hA)) $display("FAIL arst_reload got %h want %h", digits, pack4(7,4'hA,4'hA,4'hA)); else passed++;
    endtask

    task automatic test_circular();
        logic [15:0] exp_win [3];
        int n;
        exp_win = '{pack4(6,0,1,6), pack4(0,1,6,0), pack4(1,6,0,1)};
        write_digit(4'd1, 1'b0);
        write_digit(4'd6, 1'b0);
        write_digit(4'd0, 1'b1);
        checks++; if (digits !== pack4(1,6,0,1)) $display("FAIL circ_first got %h want %h", digits, pack4(1,6,0,1)); else passed++;
        for (int t = 0; t < 3; t++) begin
            wait_step(n);
            checks++; if (digits !== exp_win[t]) $display("FAIL circ_tick%0d got %h want %h", t, digits, exp_win[t]); else passed++;
        end
    endtask

    initial begin
        test_reset();
`ifndef SCROLL_CIRCULAR_EN
        test_scroll_long();
        do_reset();
        test_short_static();
        do_reset();
        test_full_buffer();
`else
        test_circular();
`endif
        do_reset();
        test_clear();
        do_reset();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
